// File: rtl/cpu_acc_dispatch.sv
// Bridges the CPU EX stage and register port to NUM_CH accelerator controllers:
// dispatches instructions by select field and round-robin arbitrates register reads/writes.
module cpu_acc_dispatch #(
    parameter int NUM_CH  = 2,
    parameter int INSTR_W = 32,
    parameter int SEL_LSB = 25,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int NUM_RP  = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [INSTR_W-1:0]               acc_instr_i,
    input  logic                             acc_instr_valid_i,
    output logic                             ready_o,
    output logic                             busy_o,
    output logic                             err_o,
    output logic [NUM_RP*ADDR_W-1:0]         reg_raddr_o,
    output logic                             reg_rready_o,
    input  logic [NUM_RP*DATA_W-1:0]         reg_rdata_i,
    input  logic                             reg_rvalid_i,
    output logic [ADDR_W-1:0]                reg_waddr_o,
    output logic [DATA_W-1:0]                reg_wdata_o,
    output logic                             reg_wren_o,
    input  logic                             reg_wready_i,
    output logic [INSTR_W-1:0]               ch_instr_o,
    output logic [NUM_CH-1:0]                ch_instr_valid_o,
    input  logic [NUM_CH-1:0]                ch_ready_i,
    input  logic [NUM_CH-1:0]                ch_busy_i,
    input  logic [NUM_CH*NUM_RP*ADDR_W-1:0]  ch_raddr_i,
    input  logic [NUM_CH-1:0]                ch_rready_i,
    output logic [NUM_RP*DATA_W-1:0]         ch_rdata_o,
    output logic [NUM_CH-1:0]                ch_rvalid_o,
    input  logic [NUM_CH*ADDR_W-1:0]         ch_waddr_i,
    input  logic [NUM_CH*DATA_W-1:0]         ch_wdata_i,
    input  logic [NUM_CH-1:0]                ch_wren_i,
    output logic [NUM_CH-1:0]                ch_wready_o
);

    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RAW = NUM_RP * ADDR_W;

    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;
    typedef enum logic {WR_IDLE, WR_WAIT} wr_state_e;

    // Returns {found, index} of the first request at or after ptr, wrapping modulo NUM_CH.
    function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] ptr);
        logic [CW:0]   res;
        logic [CW-1:0] idx;
        int            pos;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            idx = CW'(pos);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] g);
        return (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
    endfunction

    // ---------------- instruction dispatch ----------------
    logic                hold_v_q;
    logic [CW-1:0]       hold_sel_q;
    logic [INSTR_W-1:0]  hold_instr_q;
    logic                err_q;
    logic                rdy_en_q;
    logic [CW-1:0]       sel_d;
    logic                sel_bad;
    logic                hold_clr;
    logic                accept;

    assign sel_d    = (NUM_CH == 1) ? '0 : acc_instr_i[SEL_LSB +: CW];
    assign sel_bad  = (int'(sel_d) >= NUM_CH);
    assign hold_clr = hold_v_q & ch_ready_i[hold_sel_q];
    // rdy_en_q keeps ready_o low during reset and for the first cycle after release.
    assign ready_o  = rdy_en_q & (~hold_v_q | hold_clr);
    assign accept   = acc_instr_valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en_q     <= 1'b0;
            err_q        <= 1'b0;
            hold_v_q     <= 1'b0;
            hold_sel_q   <= '0;
            hold_instr_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= accept & sel_bad;
            if (accept & ~sel_bad) begin
                hold_v_q     <= 1'b1;
                hold_sel_q   <= sel_d;
                hold_instr_q <= acc_instr_i;
            end else if (hold_clr) begin
                hold_v_q <= 1'b0;
            end
        end
    end

    assign err_o      = err_q;
    assign busy_o     = hold_v_q | (|ch_busy_i);
    assign ch_instr_o = hold_instr_q;

    always_comb begin
        ch_instr_valid_o = '0;
        if (hold_v_q) ch_instr_valid_o[hold_sel_q] = 1'b1;
    end

    // ---------------- read arbiter ----------------
    rd_state_e      rd_state_q;
    logic [CW-1:0]  rptr_q;
    logic [CW-1:0]  rgnt_q;
    logic [CW:0]    rd_pick;

    assign rd_pick = rr_pick(ch_rready_i, rptr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= RD_IDLE;
            rptr_q     <= '0;
            rgnt_q     <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (rd_pick[CW]) begin
                    rgnt_q     <= rd_pick[CW-1:0];
                    rd_state_q <= RD_WAIT;
                end
                RD_WAIT: if (reg_rvalid_i) begin
                    rptr_q     <= rr_next(rgnt_q);
                    rd_state_q <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign reg_rready_o = (rd_state_q == RD_WAIT);
    assign ch_rdata_o   = reg_rdata_i;

    always_comb begin
        reg_raddr_o = '0;
        ch_rvalid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reg_rready_o && rgnt_q == CW'(c)) begin
                reg_raddr_o    = ch_raddr_i[c*RAW +: RAW];
                ch_rvalid_o[c] = reg_rvalid_i;
            end
        end
    end

    // ---------------- write arbiter ----------------
    wr_state_e      wr_state_q;
    logic [CW-1:0]  wptr_q;
    logic [CW-1:0]  wgnt_q;
    logic [CW:0]    wr_pick;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign wr_pick = rr_pick(ch_wren_i, wptr_q);

    always_comb begin
        waddr_d = '0;
        wdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_pick[CW-1:0] == CW'(c)) begin
                waddr_d = ch_waddr_i[c*ADDR_W +: ADDR_W];
                wdata_d = ch_wdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= WR_IDLE;
            wptr_q     <= '0;
            wgnt_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: if (wr_pick[CW]) begin
                    wgnt_q     <= wr_pick[CW-1:0];
                    waddr_q    <= waddr_d;
                    wdata_q    <= wdata_d;
                    wr_state_q <= WR_WAIT;
                end
                WR_WAIT: if (reg_wready_i) begin
                    wptr_q     <= rr_next(wgnt_q);
                    wr_state_q <= WR_IDLE;
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    assign reg_wren_o  = (wr_state_q == WR_WAIT);
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;

    always_comb begin
        ch_wready_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reg_wren_o && wgnt_q == CW'(c)) ch_wready_o[c] = reg_wready_i;
        end
    end

endmodule

// File: tb/tb_cpu_acc_dispatch.sv
// Bench for cpu_acc_dispatch with three channels: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_cpu_acc_dispatch;

    localparam int N   = 3;
    localparam int IW  = 32;
    localparam int SL  = 25;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int RP  = 3;
    localparam int CW  = 2;
    localparam int RAW = RP * AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [IW-1:0]      acc_instr_i;
    logic               acc_instr_valid_i;
    logic               ready_o, busy_o, err_o;
    logic [RAW-1:0]     reg_raddr_o;
    logic               reg_rready_o;
    logic [RP*DW-1:0]   reg_rdata_i;
    logic               reg_rvalid_i;
    logic [AW-1:0]      reg_waddr_o;
    logic [DW-1:0]      reg_wdata_o;
    logic               reg_wren_o;
    logic               reg_wready_i;
    logic [IW-1:0]      ch_instr_o;
    logic [N-1:0]       ch_instr_valid_o;
    logic [N-1:0]       ch_ready_i, ch_busy_i;
    logic [N*RAW-1:0]   ch_raddr_i;
    logic [N-1:0]       ch_rready_i;
    logic [RP*DW-1:0]   ch_rdata_o;
    logic [N-1:0]       ch_rvalid_o;
    logic [N*AW-1:0]    ch_waddr_i;
    logic [N*DW-1:0]    ch_wdata_i;
    logic [N-1:0]       ch_wren_i;
    logic [N-1:0]       ch_wready_o;

    cpu_acc_dispatch #(
        .NUM_CH(N), .INSTR_W(IW), .SEL_LSB(SL), .ADDR_W(AW), .DATA_W(DW), .NUM_RP(RP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .acc_instr_i(acc_instr_i), .acc_instr_valid_i(acc_instr_valid_i),
        .ready_o(ready_o), .busy_o(busy_o), .err_o(err_o),
        .reg_raddr_o(reg_raddr_o), .reg_rready_o(reg_rready_o),
        .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .reg_wren_o(reg_wren_o), .reg_wready_i(reg_wready_i),
        .ch_instr_o(ch_instr_o), .ch_instr_valid_o(ch_instr_valid_o),
        .ch_ready_i(ch_ready_i), .ch_busy_i(ch_busy_i),
        .ch_raddr_i(ch_raddr_i), .ch_rready_i(ch_rready_i),
        .ch_rdata_o(ch_rdata_o), .ch_rvalid_o(ch_rvalid_o),
        .ch_waddr_i(ch_waddr_i), .ch_wdata_i(ch_wdata_i),
        .ch_wren_i(ch_wren_i), .ch_wready_o(ch_wready_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending instruction, current read/write owner (-1 = none)
    // and the channel that has first priority for the next grant.
    bit            m_init;
    bit            mh_v;
    int            mh_sel;
    logic [IW-1:0] mh_instr;
    bit            m_err;
    int            rd_own, wr_own, rptr, wptr, rd_done, wr_done;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 0; mh_v = 0; mh_sel = 0; mh_instr = '0; m_err = 0;
        rd_own = -1; wr_own = -1; rptr = 0; wptr = 0;
        rd_done = -1; wr_done = -1; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_step();
        bit acc;
        int sel;
        int p;
        rd_done = -1;
        wr_done = -1;
        acc = acc_instr_valid_i && m_init && (!mh_v || ch_ready_i[mh_sel]);
        sel = int'(acc_instr_i[SL +: CW]);
        m_err = acc && (sel >= N);
        if (acc && sel < N) begin
            mh_v = 1; mh_sel = sel; mh_instr = acc_instr_i;
        end else if (mh_v && ch_ready_i[mh_sel]) begin
            mh_v = 0;
        end
        m_init = 1;
        if (rd_own >= 0) begin
            if (reg_rvalid_i) begin
                rptr = (rd_own + 1) % N; rd_done = rd_own; rd_own = -1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                p = (rptr + i) % N;
                if (ch_rready_i[p]) begin rd_own = p; break; end
            end
        end
        if (wr_own >= 0) begin
            if (reg_wready_i) begin
                wptr = (wr_own + 1) % N; wr_done = wr_own; wr_own = -1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                p = (wptr + i) % N;
                if (ch_wren_i[p]) begin
                    wr_own = p;
                    m_waddr = ch_waddr_i[p*AW +: AW];
                    m_wdata = ch_wdata_i[p*DW +: DW];
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] civ, crv, cwr;
        civ = '0; crv = '0; cwr = '0;
        if (mh_v) civ[mh_sel] = 1'b1;
        if (rd_own >= 0 && reg_rvalid_i) crv[rd_own] = 1'b1;
        if (wr_own >= 0 && reg_wready_i) cwr[wr_own] = 1'b1;
        chk("ready", ready_o, m_init && (!mh_v || ch_ready_i[mh_sel]));
        chk("busy", busy_o, mh_v || (|ch_busy_i));
        chk("err", err_o, m_err);
        chk("ch_instr_valid", ch_instr_valid_o, civ);
        if (mh_v) chk("ch_instr", ch_instr_o, mh_instr);
        chk("reg_rready", reg_rready_o, rd_own >= 0);
        if (rd_own >= 0) chk("reg_raddr", reg_raddr_o, ch_raddr_i[rd_own*RAW +: RAW]);
        chk("ch_rdata", ch_rdata_o, reg_rdata_i);
        chk("ch_rvalid", ch_rvalid_o, crv);
        chk("reg_wren", reg_wren_o, wr_own >= 0);
        chk("reg_waddr", reg_waddr_o, m_waddr);
        chk("reg_wdata", reg_wdata_o, m_wdata);
        chk("ch_wready", ch_wready_o, cwr);
    endtask

    // Checks at the falling edge, advances the model at the rising edge, and
    // retires the request of any channel whose transaction just completed.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        if (rd_done >= 0) ch_rready_i[rd_done] = 1'b0;
        if (wr_done >= 0) ch_wren_i[wr_done] = 1'b0;
    endtask

    task automatic rand_drive();
        acc_instr_valid_i = 1'($urandom_range(0, 1));
        acc_instr_i       = $urandom;
        ch_ready_i        = N'($urandom);
        ch_busy_i         = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        reg_rvalid_i      = ($urandom_range(0, 2) == 0);
        reg_wready_i      = ($urandom_range(0, 2) == 0);
        reg_rdata_i       = {$urandom, $urandom, $urandom};
        for (int c = 0; c < N; c++) begin
            if (!ch_rready_i[c] && $urandom_range(0, 2) == 0) begin
                ch_rready_i[c] = 1'b1;
                ch_raddr_i[c*RAW +: RAW] = RAW'($urandom);
            end
            if (!ch_wren_i[c] && $urandom_range(0, 2) == 0) begin
                ch_wren_i[c] = 1'b1;
                ch_waddr_i[c*AW +: AW] = AW'($urandom);
                ch_wdata_i[c*DW +: DW] = $urandom;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        acc_instr_i = '0; acc_instr_valid_i = 1'b0;
        reg_rdata_i = '0; reg_rvalid_i = 1'b0; reg_wready_i = 1'b0;
        ch_ready_i = '0; ch_busy_i = '0; ch_raddr_i = '0; ch_rready_i = '0;
        ch_waddr_i = '0; ch_wdata_i = '0; ch_wren_i = '0;
        model_reset();
        cycle();
        cycle();
        chk("rst_ready", ready_o, 1'b0);
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", ready_o, 1'b0);
        cycle();
        chk("ready_after_release", ready_o, 1'b1);

        // dispatch to channel 1
        ch_ready_i = 3'b010;
        acc_instr_i = 32'h0200_0011;
        acc_instr_valid_i = 1'b1;
        cycle();
        acc_instr_valid_i = 1'b0;
        #1 chk("disp_civ_sel1", ch_instr_valid_o, 3'b010);
        chk("disp_ready", ready_o, 1'b1);
        cycle();

        // back-to-back sel 0 then sel 1
        ch_ready_i = 3'b011;
        acc_instr_valid_i = 1'b1;
        acc_instr_i = 32'h0000_00A0;
        cycle();
        acc_instr_i = 32'h0200_00B0;
        #1 chk("b2b_civ0", ch_instr_valid_o, 3'b001);
        cycle();
        acc_instr_valid_i = 1'b0;
        #1 chk("b2b_civ1", ch_instr_valid_o, 3'b010);
        cycle();

        // stall while the target channel is not ready
        ch_ready_i = 3'b000;
        acc_instr_valid_i = 1'b1;
        acc_instr_i = 32'h0400_0000;
        cycle();
        acc_instr_i = 32'h0000_0001;
        #1 chk("stall_ready", ready_o, 1'b0);
        chk("stall_busy", busy_o, 1'b1);
        cycle();
        chk("stall_civ", ch_instr_valid_o, 3'b100);
        acc_instr_valid_i = 1'b0;
        ch_ready_i = 3'b100;
        cycle();
        cycle();

        // illegal select 3
        acc_instr_i = 32'h0600_0000;
        acc_instr_valid_i = 1'b1;
        cycle();
        acc_instr_valid_i = 1'b0;
        #1 chk("illegal_err", err_o, 1'b1);
        chk("illegal_civ", ch_instr_valid_o, 3'b000);
        chk("illegal_busy", busy_o, 1'b0);
        cycle();
        chk("illegal_err_pulse", err_o, 1'b0);

        // read round robin between channels 0 and 1
        ch_raddr_i = {15'h7FFF, 15'h1234, 15'h0421};
        ch_rready_i = 3'b011;
        for (int k = 0; k < 4; k++) begin
            cycle();
            cycle();
            reg_rvalid_i = 1'b1;
            reg_rdata_i = {32'h1111_0000 + k, 32'h2222_0000, 32'h3333_0000};
            #1 chk("rr_grant", ch_rvalid_o, (k % 2 == 0) ? 3'b001 : 3'b010);
            chk("rr_rdata", ch_rdata_o, {32'h1111_0000 + k, 32'h2222_0000, 32'h3333_0000});
            cycle();
            reg_rvalid_i = 1'b0;
            ch_rready_i = 3'b011;
        end
        ch_rready_i = 3'b000;
        cycle();

        // delayed write from channel 1
        ch_waddr_i[AW +: AW] = 5'd5;
        ch_wdata_i[DW +: DW] = 32'hDEAD_BEEF;
        ch_wren_i = 3'b010;
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1 chk("wr_addr_hold", reg_waddr_o, 5'd5);
            chk("wr_data_hold", reg_wdata_o, 32'hDEAD_BEEF);
            chk("wr_no_ack", ch_wready_o, 3'b000);
            cycle();
        end
        reg_wready_i = 1'b1;
        #1 chk("wr_ack", ch_wready_o, 3'b010);
        chk("wr_addr_last", reg_waddr_o, 5'd5);
        cycle();
        reg_wready_i = 1'b0;
        #1 chk("wr_ack_gone", ch_wready_o, 3'b000);
        cycle();

        // concurrent read (ch0) and write (ch1)
        ch_rready_i = 3'b001;
        ch_wren_i = 3'b010;
        ch_wdata_i[DW +: DW] = 32'h0BAD_F00D;
        cycle();
        #1 chk("conc_rready", reg_rready_o, 1'b1);
        chk("conc_wren", reg_wren_o, 1'b1);
        reg_rvalid_i = 1'b1;
        cycle();
        reg_rvalid_i = 1'b0;
        #1 chk("conc_wr_still", reg_wren_o, 1'b1);
        reg_wready_i = 1'b1;
        cycle();
        reg_wready_i = 1'b0;
        cycle();

        // reset while a read is outstanding
        ch_rready_i = 3'b100;
        cycle();
        #1 chk("mid_rready", reg_rready_o, 1'b1);
        rst_n = 1'b0;
        #1 chk("rst_drops_rready", reg_rready_o, 1'b0);
        model_reset();
        ch_rready_i = '0;
        ch_wren_i = '0;
        cycle();
        rst_n = 1'b1;
        reg_rvalid_i = 1'b1;
        #1 chk("late_rvalid", ch_rvalid_o, 3'b000);
        cycle();
        reg_rvalid_i = 1'b0;
        cycle();

        for (int n = 0; n < 600; n++) begin
            rand_drive();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
